// File: rtl/mem_bus_interface.sv
// Memory-port stage: request/ready handshake to shared memory, latches IR and MDR, stalls the controller.
// Optional access timeout with sticky mem_err when MEM_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a store/fetch/load strobe
// BUSY  | request outstanding, waiting for bus_ready
// DONE  | one-cycle completion, controller advances
module mem_bus_interface #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IorD,
   input  logic              IRWrite,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] instr,
   output logic [5:0]        opcode,
   output logic [DATA_W-1:0] mdr,
   output logic              stall,
   output logic              mem_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {K_STORE, K_FETCH, K_LOAD} kind_t;

   state_t state, state_nxt;
   kind_t  kind, kind_nxt;
   logic   req, accept, complete, abort, timeout_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      req       = MemWrite | IRWrite | MemRead;
      kind_nxt  = MemWrite ? K_STORE : (IRWrite ? K_FETCH : K_LOAD);
      state_nxt = state;
      stall     = 1'b0;
      accept    = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               stall     = 1'b1;
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (bus_ready) begin
               complete  = 1'b1;
               state_nxt = DONE;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind      <= K_LOAD;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         instr     <= '0;
         mdr       <= '0;
      end else begin
         if (accept) begin
            kind      <= kind_nxt;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= IorD ? alu_out : pc;
            bus_wdata <= wdata;
         end
         if (complete || abort) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
         end
         if (complete && kind == K_FETCH) instr <= bus_rdata;
         if (complete && kind == K_LOAD)  mdr   <= bus_rdata;
      end
   end

   assign opcode = instr[31:26];

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt;

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         if (accept)                      cnt <= '0;
         else if (state == BUSY && !abort) cnt <= cnt + CNT_W'(1);
         if (accept)     mem_err <= 1'b0;
         else if (abort) mem_err <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timeout_hit    = 1'b0;
   assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface: scoreboard of expected IR/MDR per access, immediate-assertion checks.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_bus_interface;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          IorD, IRWrite, MemWrite, MemRead;
   logic [AW-1:0] pc, alu_out;
   logic [DW-1:0] wdata;
   logic [DW-1:0] instr, mdr;
   logic [5:0]    opcode;
   logic          stall, mem_err, bus_req, bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, bus_rdata;
   logic          bus_ready;

   always #5 clk = ~clk;

   mem_bus_interface #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .MemRead(MemRead), .pc(pc), .alu_out(alu_out), .wdata(wdata), .instr(instr),
      .opcode(opcode), .mdr(mdr), .stall(stall), .mem_err(mem_err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] mdr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_instr, m_mdr;
   int          npass = 0;
   int          nfail = 0;
   int          ntotal = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 in IDLE; returns at posedge+1 in IDLE.
   task automatic access(input logic mw, input logic ir, input logic mr, input logic iord,
                         input logic [31:0] a_pc, input logic [31:0] a_alu,
                         input logic [31:0] a_wd, input int waits,
                         input logic [31:0] rdata, input string tag);
      logic [31:0] exp_addr;
      int          stall_n;
      exp_t        e;
      exp_addr = iord ? a_alu : a_pc;
      if (!mw && ir)            m_instr = rdata;
      else if (!mw && !ir && mr) m_mdr = rdata;
      e.instr = m_instr;
      e.mdr   = m_mdr;
      sb.push_back(e);

      IorD = iord; pc = a_pc; alu_out = a_alu; wdata = a_wd;
      MemWrite = mw; IRWrite = ir; MemRead = mr;
      stall_n = 0;
      @(negedge clk); if (stall) stall_n++;
      @(posedge clk); #1;
      MemWrite = 0; IRWrite = 0; MemRead = 0;
      pc = $urandom; alu_out = $urandom; wdata = $urandom; IorD = ~iord;
      check({tag, " bus_req"}, 64'(bus_req), 64'(1));
      check({tag, " bus_addr"}, 64'(bus_addr), 64'(exp_addr));
      check({tag, " bus_we"}, 64'(bus_we), 64'(mw));
      check({tag, " bus_wdata"}, 64'(bus_wdata), 64'(a_wd));
      check({tag, " mem_err clr"}, 64'(mem_err), 64'(0));
      for (int i = 0; i < waits; i++) begin
         @(negedge clk); if (stall) stall_n++;
         check({tag, " addr held"}, 64'(bus_addr), 64'(exp_addr));
         check({tag, " wdata held"}, 64'(bus_wdata), 64'(a_wd));
         check({tag, " we held"}, 64'(bus_we), 64'(mw));
         @(posedge clk); #1;
         pc = $urandom; alu_out = $urandom; wdata = $urandom;
      end
      bus_ready = 1; bus_rdata = rdata;
      @(negedge clk); if (stall) stall_n++;
      @(posedge clk); #1;
      bus_ready = 0; bus_rdata = $urandom;
      MemRead = 1;
      @(negedge clk); if (stall) stall_n++;
      check({tag, " stall cycles"}, 64'(stall_n), 64'(waits + 2));
      check({tag, " done bus_req"}, 64'(bus_req), 64'(0));
      check({tag, " done bus_we"}, 64'(bus_we), 64'(0));
      if (sb.size() == 0) check({tag, " sb empty"}, 64'(0), 64'(1));
      else begin
         e = sb.pop_front();
         check({tag, " instr"}, 64'(instr), 64'(e.instr));
         check({tag, " mdr"}, 64'(mdr), 64'(e.mdr));
         check({tag, " opcode"}, 64'(opcode), 64'(e.instr[31:26]));
      end
      @(posedge clk); #1;
      MemRead = 0;
      @(negedge clk);
      check({tag, " done strobe ignored"}, 64'(bus_req), 64'(0));
      check({tag, " idle stall"}, 64'(stall), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      int busy_n;
      rst_n = 0; IorD = 0; IRWrite = 0; MemWrite = 0; MemRead = 0;
      pc = '0; alu_out = '0; wdata = '0; bus_rdata = '0; bus_ready = 0;
      m_instr = '0; m_mdr = '0;
      #12;
      check("rst instr", 64'(instr), 64'(0));
      check("rst mdr", 64'(mdr), 64'(0));
      check("rst bus_addr", 64'(bus_addr), 64'(0));
      check("rst bus_wdata", 64'(bus_wdata), 64'(0));
      check("rst bus_req", 64'(bus_req), 64'(0));
      check("rst bus_we", 64'(bus_we), 64'(0));
      check("rst mem_err", 64'(mem_err), 64'(0));
      check("rst stall", 64'(stall), 64'(0));
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      access(0, 1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 32'h20080005, "fetch");
      check("fetch opcode val", 64'(opcode), 64'(8));
      access(0, 0, 1, 1, 32'h0, 32'h1004, 32'h0, 3, 32'hDEADBEEF, "load");
      access(1, 0, 0, 1, 32'h0, 32'h2000, 32'h12345678, 2, 32'hBAD0BAD0, "store");
      access(1, 1, 0, 0, 32'h300, 32'h0, 32'hA5A5A5A5, 1, 32'hCAFEF00D, "mw_ir prio");
      access(0, 1, 1, 1, 32'h0, 32'h500, 32'h0, 0, 32'h8C000010, "ir_mr prio");

      // reset during a fetch with 5 wait cycles
      IorD = 0; pc = 32'h80; IRWrite = 1;
      @(posedge clk); #1;
      IRWrite = 0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check("midrst bus_req", 64'(bus_req), 64'(0));
      check("midrst instr", 64'(instr), 64'(0));
      check("midrst mdr", 64'(mdr), 64'(0));
      check("midrst bus_addr", 64'(bus_addr), 64'(0));
      check("midrst stall", 64'(stall), 64'(0));
      @(negedge clk); #1; rst_n = 1;
      m_instr = '0; m_mdr = '0;
      @(posedge clk); #1;
      check("postrst stall", 64'(stall), 64'(0));
      check("postrst bus_req", 64'(bus_req), 64'(0));
      access(0, 1, 0, 0, 32'h44, 32'h0, 32'h0, 1, 32'h01234567, "postrst fetch");

`ifdef MEM_TIMEOUT_EN
      IorD = 0; pc = 32'h100; IRWrite = 1;
      @(posedge clk); #1;
      IRWrite = 0;
      busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stall) break;
         busy_n++;
         @(posedge clk); #1;
      end
      check("to busy cycles", 64'(busy_n), 64'(TO));
      check("to mem_err", 64'(mem_err), 64'(1));
      check("to bus_req", 64'(bus_req), 64'(0));
      check("to instr", 64'(instr), 64'(m_instr));
      @(posedge clk); #1;
      @(negedge clk);
      check("to sticky", 64'(mem_err), 64'(1));
      @(posedge clk); #1;
      access(0, 0, 1, 1, 32'h0, 32'h1008, 32'h0, 0, 32'h55AA55AA, "after timeout");
`else
      busy_n = 0;
      check("no-timeout mem_err", 64'(mem_err), 64'(busy_n));
`endif

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Multicycle memory-port stage between the main controller and the shared instruction/data memory. Consumes the controller's IorD, IRWrite and MemWrite strobes plus a load strobe. Runs a request/ready handshake to a variable-latency memory and latches fetched words into the instruction register (IR) and loaded words into the memory data register (MDR). Asserts `stall` so the controller's state register holds until the access completes.

## Interface
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `IorD`  in  1  address select: 0 = `pc`, 1 = `alu_out`
- `IRWrite`  in  1  instruction fetch request
- `MemWrite`  in  1  store request
- `MemRead`  in  1  load request
- `pc`  in  ADDR_W  program counter
- `alu_out`  in  ADDR_W  data address
- `wdata`  in  DATA_W  store data (register B)
- `instr`  out  DATA_W  IR contents
- `opcode`  out  6  `instr[31:26]`, fed to the controller
- `mdr`  out  DATA_W  MDR contents
- `stall`  out  1  controller hold
- `mem_err`  out  1  access aborted by timeout (sticky)
- `bus_req`  out  1  memory request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  ADDR_W  access address
- `bus_wdata`  out  DATA_W  write data
- `bus_rdata`  in  DATA_W  read data, valid when `bus_ready`=1
- `bus_ready`  in  1  memory completion

## Operation
- Reset values: state IDLE; `instr`, `mdr`, `bus_addr` and `bus_wdata` are 0; `bus_req`, `bus_we` and `mem_err` are 0. The stall output evaluates to 0 because no request is pending at reset.
- States: IDLE, BUSY, DONE.
- **IDLE:**
  - A request is any of MemWrite, IRWrite or MemRead. Priority on simultaneous strobes: MemWrite > IRWrite > MemRead.
  - On a request, register the following at the next edge and go to BUSY:
    - `bus_addr` = IorD ? `alu_out` : `pc`
    - `bus_wdata` = `wdata`
    - `bus_we` = 1 for a store
    - access kind (store, fetch or load)
    - `bus_req` = 1
  - Clear `mem_err` at that same edge.
- **BUSY:**
  - `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` are held stable. Input changes are ignored.
  - On an edge with `bus_ready`=1:
    - Fetch loads `instr` with `bus_rdata`. Load loads `mdr` with `bus_rdata`. Store loads nothing.
    - `bus_req` and `bus_we` go to 0.
    - Go to DONE.
- **DONE:** lasts one cycle with `stall`=0, so the controller advances at this edge. Request strobes are ignored during DONE. Return to IDLE.
- `stall` is combinational: (IDLE and any request) or BUSY.
- `instr` and `mdr` change only on their own completing access. Otherwise they hold.
- `rst_n` asserted mid-access forces every register to its reset value immediately. The in-flight access is dropped and no IR/MDR update occurs.

## Timing
- Zero-wait memory (`bus_ready`=1 in the first BUSY cycle):
  - request seen in IDLE at cycle N
  - BUSY at N+1; `instr`/`mdr` valid from N+2
  - DONE at N+2
  - controller advances at the end of N+2
  - 3 cycles per access
- Each additional wait cycle adds one BUSY cycle.
- `bus_req` is registered and rises one cycle after the request is sampled.
- `opcode` follows `instr` with no added latency.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter of width clog2(TIMEOUT) counts BUSY cycles from 0.
  - If `bus_ready` is still 0 on the edge where the count equals TIMEOUT-1, the access is aborted:
    - `bus_req` and `bus_we` go to 0
    - `mem_err` is set to 1
    - `instr` and `mdr` are unchanged
    - go to DONE
  - `mem_err` stays 1 until the next request is accepted in IDLE.
- **`MEM_TIMEOUT_EN` undefined:**
  - BUSY waits indefinitely.
  - The counter is not built.
  - `mem_err` is constant 0.

## Test plan
- Fetch with `pc`=0x40, IorD=0, memory zero-wait returning 0x20080005:
  - `bus_addr`=0x40, `bus_we`=0
  - `stall` high for 2 cycles
  - `instr`=0x20080005 and `opcode`=0x08 in the DONE cycle
- Load with IorD=1, `alu_out`=0x1004, 3 wait cycles, `bus_rdata`=0xDEADBEEF:
  - `stall` high for 5 cycles
  - `mdr`=0xDEADBEEF
  - `instr` unchanged
- Store with `alu_out`=0x2000, `wdata`=0x12345678:
  - `bus_we`=1, `bus_wdata`=0x12345678 held through BUSY
  - `instr` and `mdr` unchanged
- MemWrite and IRWrite both high in IDLE:
  - a store is issued (`bus_we`=1)
  - no IR update
- `rst_n` pulled low during BUSY of a fetch with 5 wait cycles:
  - `bus_req`=0 and `instr`=0 immediately
  - state IDLE after release
- With MEM_TIMEOUT_EN, TIMEOUT=16, `bus_ready` held 0:
  - abort after 16 BUSY cycles
  - `mem_err`=1, `stall` drops in DONE
  - the next accepted request clears `mem_err`
